// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry pipeline skid register with registered in_ready.
//               Optional stall counter enabled by macro PIPE_SKID_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int WIDTH = 92,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    generate
        if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
            $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
        end
    endgenerate

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt      = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Handshake flags are precomputed from the next state so both ports come straight from flops.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state     <= S_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Flush deliberately does not clear the statistic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Testbench for pipe_skid_reg: vector table plus hand-written corner sequences.
module tb_pipe_skid_reg;

    localparam int W  = 92;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [CW-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ov;
        logic         e_ir;
        logic [W-1:0] e_d;
        logic [1:0]   e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic e_ov, input logic e_ir,
                       input logic [W-1:0] e_d, input logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_d = e_d; v.e_occ = e_occ;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //   rst fl iv data     ordy | ov ir data     occ
        add(1, 0, 1, 92'h5A,  0,    0, 1, 92'h0,  2'd0); // reset ignores inputs
        add(0, 0, 1, 92'h1,   1,    1, 1, 92'h1,  2'd1); // streaming
        add(0, 0, 1, 92'h2,   1,    1, 1, 92'h2,  2'd1);
        add(0, 0, 1, 92'h3,   1,    1, 1, 92'h3,  2'd1);
        add(0, 0, 0, 92'h0,   1,    0, 1, 92'h3,  2'd0); // empty keeps last payload
        add(0, 0, 1, 92'hA,   0,    1, 1, 92'hA,  2'd1); // fill to TWO
        add(0, 0, 1, 92'hB,   0,    1, 0, 92'hA,  2'd2);
        add(0, 0, 1, 92'hC,   0,    1, 0, 92'hA,  2'd2); // ignored while full
        add(0, 0, 0, 92'h0,   1,    1, 1, 92'hB,  2'd1);
        add(0, 0, 0, 92'h0,   1,    0, 1, 92'hB,  2'd0);
        add(0, 0, 1, 92'h11,  0,    1, 1, 92'h11, 2'd1);
        add(0, 0, 1, 92'h12,  0,    1, 0, 92'h11, 2'd2);
        add(0, 1, 1, 92'h13,  1,    0, 1, 92'h0,  2'd0); // flush in TWO
        add(0, 0, 1, 92'h21,  0,    1, 1, 92'h21, 2'd1);
        add(1, 1, 1, 92'h22,  1,    0, 1, 92'h0,  2'd0); // reset+flush in ONE
        add(0, 0, 1, 92'h31,  0,    1, 1, 92'h31, 2'd1);
        add(0, 0, 1, 92'h32,  0,    1, 0, 92'h31, 2'd2);
        add(1, 0, 1, 92'h33,  1,    0, 1, 92'h0,  2'd0); // reset in TWO
        add(0, 0, 1, 92'h41,  1,    1, 1, 92'h41, 2'd1);
        add(0, 0, 1, 92'h42,  1,    1, 1, 92'h42, 2'd1);
        add(0, 0, 1, 92'h43,  0,    1, 0, 92'h42, 2'd2);
        add(0, 0, 1, 92'h44,  1,    1, 1, 92'h43, 2'd1); // skid drains, no intake
        add(0, 0, 0, 92'h0,   1,    0, 1, 92'h43, 2'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("v%0d out_valid", i), {127'b0, out_valid}, {127'b0, tbl[i].e_ov});
            chk($sformatf("v%0d in_ready", i),  {127'b0, in_ready},  {127'b0, tbl[i].e_ir});
            chk($sformatf("v%0d out_data", i),  {36'b0, out_data},   {36'b0, tbl[i].e_d});
            chk($sformatf("v%0d occupancy", i), {126'b0, occupancy}, {126'b0, tbl[i].e_occ});
        end

        // Stream of 8 with out_ready toggling: order must be preserved, nothing lost.
        begin
            logic [W-1:0] exp_q[$];
            int sent = 0;
            int got  = 0;
            drive(1, 0, 0, '0, 0);
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                logic [W-1:0] d;
                logic iv, ordy, fire_in, fire_out;
                iv   = (sent < 8);
                ordy = (cyc % 3) != 1;
                d    = W'(32'hC0 + sent);
                reset = 0; flush = 0; in_valid = iv; in_data = d; out_ready = ordy;
                #1;
                fire_in  = iv & in_ready;
                fire_out = out_valid & ordy;
                if (fire_out) begin
                    chk("stream order", {36'b0, out_data}, {36'b0, exp_q.pop_front()});
                    got++;
                end
                if (fire_in) begin
                    exp_q.push_back(d);
                    sent++;
                end
                @(posedge clk);
                #1;
            end
            chk("stream count", 128'(got), 128'd8);
        end

`ifdef PIPE_SKID_STATS_EN
        drive(1, 0, 0, '0, 0);
        chk("stall reset", {124'b0, stall_cnt}, 128'd0);
        drive(0, 0, 1, 92'h7, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, '0, 0);
        end
        chk("stall saturate", {124'b0, stall_cnt}, 128'd15);
        drive(0, 1, 0, '0, 0);
        chk("stall after flush", {124'b0, stall_cnt}, 128'd15);
        drive(0, 0, 0, '0, 0);
        chk("stall held", {124'b0, stall_cnt}, 128'd15);
        drive(1, 1, 1, 92'h9, 1);
        chk("stall reset+flush", {124'b0, stall_cnt}, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
